tick_shift_register: RTL and testbench
======================================

Name: tick_shift_register

Overview:
- Parametrised successor to the team's 4-bit slow-clock load register.
- A single clock domain (`clk`) contains a programmable prescaler. The prescaler produces a one-cycle clock-enable `tick` and a ~50% duty `slow_clk` indicator. No derived clocks are used.
- A WIDTH-bit register updates only on `tick`, in one of four modes: hold, parallel load, shift left, shift right.
- Sits between board switches/buttons and LED displays in the lab designs.

Parameters:
- WIDTH, 4, data register width in bits (>=2).
- DIV, 50000000, `clk` cycles per tick period (>=2); 50 MHz input gives 1 Hz.
- CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= DIV.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- en  in  1  prescaler run enable; 0 freezes the counter.
- mode  in  2  00 hold, 01 load, 10 shift left, 11 shift right.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input bit for shift modes.
- q  out  WIDTH  register contents.
- tick  out  1  one-cycle strobe; marks the edge on which q updates.
- slow_clk  out  1  registered square wave, period DIV cycles.
- sout  out  1  bit shifted out by the most recent shift.

Behaviour:
- Reset: `clr`=1 immediately forces cnt=0, q=0, sout=0, slow_clk=0. `tick` reads 0 while `clr` is high.
  - Reset mid-period discards the partial count.
  - First tick after release occurs DIV cycles later, provided `en` is held high.
- Prescaler:
  - On each rising edge with `en`=1: cnt <= (cnt==DIV-1) ? 0 : cnt+1.
  - With `en`=0, cnt holds its value.
- tick: combinational, equal to `en` AND (cnt==DIV-1). Exactly one cycle high per DIV enabled cycles.
- slow_clk: registered, slow_clk <= (cnt_next < DIV/2).
  - Goes high one cycle after reset release.
  - High for DIV/2 cycles, low for DIV-DIV/2 cycles (odd DIV: low phase is the longer one).
  - Holds its value while `en`=0.
- Register update happens only on an edge where `tick`=1. `mode`, `d` and `sin` are sampled at that edge only; changes between ticks are ignored.
  - 00: q and sout unchanged.
  - 01: q <= d; sout unchanged.
  - 10: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
  - 11: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
- Latency: q is valid the cycle after the tick edge.
- `en` falling on the tick cycle: no tick occurs, no update, cnt stays at DIV-1. The tick fires on the first cycle `en` returns high.
- `clr` asserted on the tick cycle: clear wins; no update is applied.
- Arithmetic is unsigned; there are no overflow conditions beyond the cnt wrap at DIV-1.

Optional Feature:
- Macro: TICK_SHIFT_ROTATE_EN.
- Defined: the shift modes rotate and `sin` is ignored.
  - mode 10: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - mode 11: q <= {q[0], q[WIDTH-1:1]}.
  - sout still reports the bit that crossed the boundary.
- Undefined: shift modes use `sin` exactly as specified above.

Test Plan (WIDTH=4, DIV=4, macro undefined unless stated):
- Release `clr`, `en`=1, mode=00 -> `tick` high on cycles 4, 8, 12 after release; slow_clk pattern 1,1,0,0 repeating; q stays 0000.
- mode=01, d=1011 changed to 0110 mid-period -> q=0110 only after the next tick, never 1011.
- Load 1001, then mode=10 with sin=1 for two ticks -> q=0011 then 0111; sout=1 then 0.
- Load 1001, then mode=11 with sin=0 -> q=0100, sout=1. With TICK_SHIFT_ROTATE_EN defined -> q=1100, sout=1.
- `en`=0 for 10 cycles from cnt=3 -> no tick, q and slow_clk frozen; tick fires on the first cycle `en`=1.
- Assert `clr` asynchronously (between edges) during the tick cycle with q=1111 -> q=0000 immediately and no load applied; next tick lands 4 cycles after release.

Source files
------------

// File: rtl/tick_shift_register.sv
// Prescaled shift/load register: a programmable prescaler produces a one-cycle tick
// and a slow square wave. The data register updates only on that tick.
// Optional build macro TICK_SHIFT_ROTATE_EN turns the shift modes into rotates that ignore sin.
module tick_shift_register #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50000000,
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             slow_clk,
    output logic             sout
);

    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_SHR   = 2'b11;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("tick_shift_register: WIDTH must be at least 2");
        end
        if (DIV < 2) begin : g_bad_div
            $error("tick_shift_register: DIV must be at least 2");
        end
        if ((64'd1 << CNT_W) < 64'(DIV)) begin : g_bad_cnt_w
            $error("tick_shift_register: CNT_W too narrow for DIV");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             at_tc;
    logic [WIDTH-1:0] q_next;
    logic             sout_next;

    assign at_tc = (cnt == CNT_TC);

    // Masking with clr keeps tick low during reset even before cnt has settled.
    assign tick = en & at_tc & ~clr;

    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = at_tc ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt      <= '0;
            slow_clk <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (en) begin
                slow_clk <= (cnt_next < CNT_HALF);
            end
        end
    end

    always_comb begin
        q_next    = q;
        sout_next = sout;
        if (tick) begin
            case (mode)
                MODE_HOLD: begin
                    q_next    = q;
                    sout_next = sout;
                end
                MODE_LOAD: begin
                    q_next = d;
                end
                MODE_SHL: begin
`ifdef TICK_SHIFT_ROTATE_EN
                    q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
`else
                    q_next    = {q[WIDTH-2:0], sin};
`endif
                    sout_next = q[WIDTH-1];
                end
                MODE_SHR: begin
`ifdef TICK_SHIFT_ROTATE_EN
                    q_next    = {q[0], q[WIDTH-1:1]};
`else
                    q_next    = {sin, q[WIDTH-1:1]};
`endif
                    sout_next = q[0];
                end
                default: begin
                    q_next    = q;
                    sout_next = sout;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q    <= '0;
            sout <= 1'b0;
        end else begin
            q    <= q_next;
            sout <= sout_next;
        end
    end

endmodule

// File: tb/tb_tick_shift_register.sv
// Directed bench for tick_shift_register with WIDTH=4, DIV=4. Sampling happens 1 time unit
// after each rising edge, and every step checks against hand-computed values.
module tb_tick_shift_register;

    logic       clk;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       sin;
    logic [3:0] q;
    logic       tick;
    logic       slow_clk;
    logic       sout;

    int checks;
    int failures;

    tick_shift_register #(
        .WIDTH (4),
        .DIV   (4),
        .CNT_W (3)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .sin      (sin),
        .q        (q),
        .tick     (tick),
        .slow_clk (slow_clk),
        .sout     (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Advance until tick is visible. Give up after a bounded number of edges.
    task automatic wait_tick(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (tick === 1'b1) break;
            next_edge();
        end
        check(tag, 32'(tick), 32'd1);
    endtask

    logic [3:0] q_frozen;
    logic       slow_frozen;

    initial begin
        checks   = 0;
        failures = 0;
        clr  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        d    = 4'b0000;
        sin  = 1'b0;

        #12;
        check("reset_q", 32'(q), 32'h0);
        check("reset_sout", 32'(sout), 32'd0);
        check("reset_slow", 32'(slow_clk), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);

        // Release between edges. Cycle 1 lasts until the edge at t=15.
        clr = 1'b0;
        en  = 1'b1;
        #1;
        check("cycle1_tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            next_edge();
            check($sformatf("tick_after_edge%0d", k), 32'(tick), ((k % 4) == 3) ? 32'd1 : 32'd0);
            check($sformatf("slow_after_edge%0d", k), 32'(slow_clk), ((k % 4) < 2) ? 32'd1 : 32'd0);
            check($sformatf("hold_q_edge%0d", k), 32'(q), 32'h0);
        end

        // Load with d changing mid-period. Only the value present at the tick is captured.
        mode = 2'b01;
        d    = 4'b1011;
        next_edge();
        check("load_pre1_q", 32'(q), 32'h0);
        next_edge();
        check("load_pre2_q", 32'(q), 32'h0);
        d = 4'b0110;
        next_edge();
        check("load_tick_vis", 32'(tick), 32'd1);
        check("load_pre3_q", 32'(q), 32'h0);
        next_edge();
        check("load_q_0110", 32'(q), 32'h6);

        // Hold mode leaves q unchanged across a tick.
        mode = 2'b00;
        d    = 4'b1111;
        wait_tick("hold_wait");
        next_edge();
        check("hold_q", 32'(q), 32'h6);
        check("hold_sout", 32'(sout), 32'd0);

        // Load 1001, then shift left twice with sin=1.
        mode = 2'b01;
        d    = 4'b1001;
        wait_tick("shl_load_wait");
        next_edge();
        check("shl_load_q", 32'(q), 32'h9);
        mode = 2'b10;
        sin  = 1'b1;
        wait_tick("shl1_wait");
        next_edge();
`ifdef TICK_SHIFT_ROTATE_EN
        check("shl1_q", 32'(q), 32'h3);
`else
        check("shl1_q", 32'(q), 32'h3);
`endif
        check("shl1_sout", 32'(sout), 32'd1);
        wait_tick("shl2_wait");
        next_edge();
`ifdef TICK_SHIFT_ROTATE_EN
        check("shl2_q", 32'(q), 32'h6);
`else
        check("shl2_q", 32'(q), 32'h7);
`endif
        check("shl2_sout", 32'(sout), 32'd0);

        // Load 1001, then shift right with sin=0.
        mode = 2'b01;
        d    = 4'b1001;
        wait_tick("shr_load_wait");
        next_edge();
        check("shr_load_q", 32'(q), 32'h9);
        mode = 2'b11;
        sin  = 1'b0;
        wait_tick("shr_wait");
        next_edge();
`ifdef TICK_SHIFT_ROTATE_EN
        check("shr_q", 32'(q), 32'hC);
`else
        check("shr_q", 32'(q), 32'h4);
`endif
        check("shr_sout", 32'(sout), 32'd1);

        // Drop en on the tick cycle and freeze for 10 edges.
        mode = 2'b01;
        d    = 4'b1111;
        wait_tick("freeze_wait");
        en = 1'b0;
        #1;
        check("freeze_tick_gone", 32'(tick), 32'd0);
        q_frozen    = q;
        slow_frozen = slow_clk;
        check("freeze_slow_low", 32'(slow_frozen), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            next_edge();
            check($sformatf("freeze_tick%0d", k), 32'(tick), 32'd0);
            check($sformatf("freeze_q%0d", k), 32'(q), 32'(q_frozen));
            check($sformatf("freeze_slow%0d", k), 32'(slow_clk), 32'(slow_frozen));
        end
        en = 1'b1;
        #1;
        check("resume_tick", 32'(tick), 32'd1);
        next_edge();
        check("resume_q", 32'(q), 32'hF);
        check("resume_slow", 32'(slow_clk), 32'd1);

        // Assert clr between edges during a tick cycle with q=1111.
        mode = 2'b01;
        d    = 4'b0101;
        wait_tick("clr_wait");
        #2;
        clr = 1'b1;
        #1;
        check("clr_q_immediate", 32'(q), 32'h0);
        check("clr_tick", 32'(tick), 32'd0);
        check("clr_slow", 32'(slow_clk), 32'd0);
        next_edge();
        check("clr_no_load", 32'(q), 32'h0);
        #3;
        clr = 1'b0;
        next_edge();
        check("post_clr_tick1", 32'(tick), 32'd0);
        check("post_clr_slow1", 32'(slow_clk), 32'd1);
        next_edge();
        check("post_clr_tick2", 32'(tick), 32'd0);
        next_edge();
        check("post_clr_tick3", 32'(tick), 32'd1);
        next_edge();
        check("post_clr_load", 32'(q), 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
